// File: rtl/ahbl_mem_slave_if.sv
// AHB-Lite slave-side bus bundle for the memory slave.
// The master modport is the bus/interconnect view: it drives the address and
// data phase signals plus the merged HREADY; the slave returns HREADYOUT,
// HRDATA and HRESP.
interface ahbl_mem_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
      input  HREADYOUT, HRDATA, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
      output HREADYOUT, HRDATA, HRESP
   );
endinterface

// File: rtl/ahbl_mem_slave.sv
// AHB-Lite word-organised memory slave with programmable wait states and a
// two-cycle ERROR response for misaligned or out-of-range transfers.
//
// state | meaning
// IDLE  | no transfer in data phase, ready high
// WAIT  | legal transfer stalled, ready low, wait counter running
// DONE  | legal transfer completing: read data driven / write committed at edge
// ERR1  | first ERROR cycle, HRESP high, ready low
// ERR2  | second ERROR cycle, HRESP high, ready high
module ahbl_mem_slave #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input logic              HCLK,
   input logic              HRESETn,
   ahbl_mem_slave_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t          state_q, state_d, target;
   logic [3:0]      wait_cnt_q;
   logic [AW-1:0]   idx_q;
   logic [1:0]      off_q;
   logic [1:0]      size_q;
   logic            wr_q;
   logic            take;
   logic            illegal;
   logic [3:0]      lanes;
   logic [31:0]     mem [DEPTH];
   logic            unused_htrans0;

   assign unused_htrans0 = bus.HTRANS[0];

   // Classify the address phase currently on the bus.
   always_comb begin
      illegal = 1'b0;
      if (bus.HSIZE > 3'd2)                                illegal = 1'b1;
      if (bus.HSIZE == 3'd1 && bus.HADDR[0])               illegal = 1'b1;
      if (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)    illegal = 1'b1;
      if (bus.HADDR[31:2] >= 30'(DEPTH))                   illegal = 1'b1;
   end

   // Next-state decode; a new transfer is only taken while ready is high.
   always_comb begin
      take    = bus.HSEL && bus.HTRANS[1] && bus.HREADY &&
                (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR2);
      target  = illegal ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DONE);
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (take) state_d = target;
         ST_WAIT: if (wait_cnt_q == 4'd0) state_d = ST_DONE;
         ST_DONE: state_d = take ? target : ST_IDLE;
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = take ? target : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register, wait counter and address-phase capture.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
         idx_q      <= '0;
         off_q      <= 2'b00;
         size_q     <= 2'b00;
         wr_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take && target == ST_WAIT)
            wait_cnt_q <= WS_LOAD;
         else if (state_q == ST_WAIT && wait_cnt_q != 4'd0)
            wait_cnt_q <= wait_cnt_q - 4'd1;
         if (take) begin
            idx_q  <= bus.HADDR[AW+1:2];
            off_q  <= bus.HADDR[1:0];
            size_q <= bus.HSIZE[1:0];
            wr_q   <= bus.HWRITE;
         end
      end
   end

   // Byte-lane enables for the write in its data phase.
   always_comb begin
      lanes = 4'b0000;
      case (size_q)
         2'd0:    lanes[off_q] = 1'b1;
         2'd1:    lanes = off_q[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
   end

   // Memory array is not reset; reset forces IDLE so no write can land.
   always_ff @(posedge HCLK) begin
      if (state_q == ST_DONE && wr_q) begin
         for (int b = 0; b < 4; b++)
            if (lanes[b]) mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
   end

   assign bus.HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
   assign bus.HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2);
   assign bus.HRDATA    = (state_q == ST_DONE && !wr_q) ? mem[idx_q] : 32'h0;

endmodule
